// File: rtl/score_pkg.sv
// score_pkg: shared types, widths and the BCD digit-adjust helper for score_ctrl
package score_pkg;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int SCORE_W    = 10;

  typedef enum logic [1:0] {
    G_IDLE    = 2'd0,
    G_PLAYING = 2'd1,
    G_OVER    = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_LOAD,
    CV_SHIFT,
    CV_DONE
  } cv_state_t;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, 10-bit binary to three BCD digits
// Result register only changes at the end of the last shift, so it is never torn.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [SCORE_W-1:0] i_bin,
  output logic               o_busy,
  output logic               o_done,
  output logic [BCD_W-1:0]   o_bcd
);
  localparam int SH_W = BCD_W + SCORE_W;

  cv_state_t r_state, w_state_nx;
  logic [SH_W-1:0] r_sh, w_adj, w_shift;
  logic [3:0] r_cnt;
  logic [BCD_W-1:0] r_bcd;
  logic w_last, w_load;

  assign w_last = r_cnt == 4'(SCORE_W - 1);
  // A start seen in CV_DONE chains straight into the next pass, the done cycle doubling as its load.
  assign w_load = (r_state == CV_LOAD) || (r_state == CV_DONE && i_start);

  always_comb begin
    w_adj = r_sh;
    for (int d = 0; d < BCD_DIGITS; d++)
      w_adj[SCORE_W+4*d +: 4] = add3(r_sh[SCORE_W+4*d +: 4]);
    w_shift = {w_adj[SH_W-2:0], 1'b0};
    w_state_nx = r_state;
    case (r_state)
      CV_IDLE:  w_state_nx = i_start ? CV_LOAD : CV_IDLE;
      CV_LOAD:  w_state_nx = CV_SHIFT;
      CV_SHIFT: w_state_nx = w_last ? CV_DONE : CV_SHIFT;
      default:  w_state_nx = i_start ? CV_SHIFT : CV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= CV_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_sh  <= {{BCD_W{1'b0}}, i_bin};
        r_cnt <= '0;
      end else if (r_state == CV_SHIFT) begin
        r_sh  <= w_shift;
        r_cnt <= r_cnt + 4'd1;
        if (w_last) r_bcd <= w_shift[SH_W-1:SCORE_W];
      end
    end
  end

  assign o_busy = r_state != CV_IDLE;
  assign o_done = r_state == CV_DONE;
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: game score, game-state sequencing and per-frame BCD conversion.
// Define SCORE_HISCORE_EN to add a high-score register and a second converter pass.
module score_ctrl
  import score_pkg::*;
#(
  parameter int FRAME_LINE  = 480,
  parameter int HOLD_FRAMES = 8,
  parameter int SCORE_MAX   = 999
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [9:0]         i_vpos,
  input  logic [9:0]         i_hpos,
  input  logic               i_move,
  input  logic               i_game_start,
  input  logic               i_game_over,
  output logic [1:0]         o_state,
  output logic [SCORE_W-1:0] o_score,
  output logic [BCD_W-1:0]   o_score_bcd,
  output logic [BCD_W-1:0]   o_hiscore_bcd,
  output logic               o_bcd_valid
);
  localparam logic [7:0]         HOLD_RELOAD = 8'(HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP   = SCORE_W'(SCORE_MAX);

  game_state_t r_state, w_state_nx;
  logic r_move_s1, r_move_s2;
  logic [SCORE_W-1:0] r_score, w_score_nx, w_bin;
  logic [7:0] r_hold, w_hold_nx;
  logic w_tick, w_start_ok, w_over, w_play_tick, w_inc;
  logic w_cv_start, w_busy, w_done;
  logic [BCD_W-1:0] w_bcd;

  assign w_tick      = (i_vpos == 10'(FRAME_LINE)) && (i_hpos == '0);
  assign w_start_ok  = i_game_start && (r_state != G_PLAYING);
  assign w_over      = i_game_over && (r_state == G_PLAYING);
  assign w_play_tick = w_tick && (r_state == G_PLAYING);
  // Game over in the same cycle drops the increment so OVER keeps the pre-increment score.
  assign w_inc = w_play_tick && r_move_s2 && (r_hold == '0) && !w_over && (r_score != SCORE_TOP);

  always_comb begin
    w_state_nx = w_start_ok ? G_PLAYING : w_over ? G_OVER : r_state;
    w_score_nx = w_start_ok ? '0 : w_inc ? r_score + 1'b1 : r_score;
    w_hold_nx  = w_start_ok ? '0 : !w_play_tick ? r_hold : !r_move_s2 ? '0 :
                 (r_hold == '0) ? HOLD_RELOAD : r_hold - 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_move_s1 <= 1'b0;
      r_move_s2 <= 1'b0;
      r_state   <= G_IDLE;
      r_score   <= '0;
      r_hold    <= '0;
    end else begin
      r_move_s1 <= i_move;
      r_move_s2 <= r_move_s1;
      r_state   <= w_state_nx;
      r_score   <= w_score_nx;
      r_hold    <= w_hold_nx;
    end
  end

  bin2bcd_seq u_b2b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_cv_start),
    .i_bin   (w_bin),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;
  logic [BCD_W-1:0] r_score_bcd, r_hi_bcd;
  logic r_pass, w_hi_start;

  assign w_hi_start = w_done && !r_pass;
  assign w_cv_start = (w_tick && !w_busy) || w_hi_start;
  assign w_bin      = (r_pass || w_hi_start) ? r_hiscore : r_score;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hiscore   <= '0;
      r_score_bcd <= '0;
      r_hi_bcd    <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (w_over && (r_score > r_hiscore)) r_hiscore <= r_score;
      if (w_done) r_pass <= !r_pass;
      if (w_done && !r_pass) r_score_bcd <= w_bcd;
      if (w_done && r_pass) r_hi_bcd <= w_bcd;
    end
  end

  // The converter result register is shown directly during its done cycle, then held locally.
  assign o_score_bcd   = (w_done && !r_pass) ? w_bcd : r_score_bcd;
  assign o_hiscore_bcd = (w_done && r_pass) ? w_bcd : r_hi_bcd;
`else
  assign w_cv_start    = w_tick && !w_busy;
  assign w_bin         = r_score;
  assign o_score_bcd   = w_bcd;
  assign o_hiscore_bcd = '0;
`endif

  assign o_state     = r_state;
  assign o_score     = r_score;
  assign o_bcd_valid = w_done;
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed stimulus with a queue-based scoreboard for score_ctrl
module tb_score_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, move = 1'b0, gstart = 1'b0, gover = 1'b0;
  logic [9:0] vpos = 10'd0, hpos = 10'd5;
  logic [1:0] state;
  logic [9:0] score;
  logic [11:0] sbcd, hbcd;
  logic valid;
  int total = 0, bad = 0, cyc = 0;
  bit sb_off = 1'b0;

`ifdef SCORE_HISCORE_EN
  localparam bit HI = 1'b1;
  localparam int GAP = 26;
`else
  localparam bit HI = 1'b0;
  localparam int GAP = 15;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic [11:0] hi;
    bit          chk_hi;
    int          at;
  } exp_t;
  exp_t sbq[$];

  score_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_vpos        (vpos),
    .i_hpos        (hpos),
    .i_move        (move),
    .i_game_start  (gstart),
    .i_game_over   (gover),
    .o_state       (state),
    .o_score       (score),
    .o_score_bcd   (sbcd),
    .o_hiscore_bcd (hbcd),
    .o_bcd_valid   (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid && !sb_off) begin
      if (sbq.size() == 0) chk("valid_without_expect", valid, 0);
      else begin : pop
        exp_t e;
        e = sbq.pop_front();
        chk("score_bcd", sbcd, e.bcd);
        chk("valid_cycle", cyc, e.at);
        if (e.chk_hi) chk("hiscore_bcd", hbcd, e.hi);
      end
    end
  end

  task automatic pulse(input bit is_start);
    @(negedge clk);
    if (is_start) gstart = 1'b1;
    else gover = 1'b1;
    @(negedge clk);
    gstart = 1'b0;
    gover  = 1'b0;
  endtask

  task automatic set_move(input logic v);
    move = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic raw_tick();
    @(negedge clk);
    vpos = 10'd480;
    hpos = 10'd0;
    @(negedge clk);
    vpos = 10'd0;
    hpos = 10'd5;
  endtask

  task automatic tick(input logic [11:0] exp, input logic [11:0] exp_hi, input logic over);
    @(negedge clk);
    vpos  = 10'd480;
    hpos  = 10'd0;
    gover = over;
    sbq.push_back('{exp, 12'h000, !HI, cyc + 12});
    if (HI) sbq.push_back('{exp, exp_hi, 1'b1, cyc + 23});
    @(negedge clk);
    vpos  = 10'd0;
    hpos  = 10'd5;
    gover = 1'b0;
    repeat (GAP - 2) @(negedge clk);
  endtask

  task automatic bump(input int n);
    sb_off = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_move(1'b1);
      raw_tick();
      set_move(1'b0);
      raw_tick();
    end
    repeat (30) @(negedge clk);
    sb_off = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    chk("rst_score_bcd", sbcd, 0);
    chk("rst_hiscore_bcd", hbcd, 0);
    chk("rst_valid", valid, 0);
    rst_n = 1'b1;
    pulse(1'b1);
    chk("start_state", state, 1);
    chk("start_score", score, 0);
    set_move(1'b1);
    tick(12'h001, 12'h000, 1'b0);
    chk("one_tick_score", score, 1);
    pulse(1'b0);
    chk("over_state", state, 2);
    chk("over_score", score, 1);
    pulse(1'b1);
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    for (int i = 0; i < 17; i++) tick(12'(1 + (i >= 8) + (i >= 16)), HI ? 12'h001 : 12'h000, 1'b0);
    chk("hold17_score", score, 3);
    pulse(1'b1);
    chk("start_ignored_state", state, 1);
    chk("start_ignored_score", score, 3);
    set_move(1'b0);
    tick(12'h003, HI ? 12'h001 : 12'h000, 1'b0);
    bump(38);
    chk("bump41_score", score, 41);
    set_move(1'b1);
    tick(12'h041, HI ? 12'h041 : 12'h000, 1'b1);
    chk("over_tie_state", state, 2);
    chk("over_tie_score", score, 41);
    pulse(1'b0);
    chk("over_ignored_state", state, 2);
    pulse(1'b1);
    chk("restart2_state", state, 1);
    chk("restart2_score", score, 0);
    set_move(1'b0);
    tick(12'h000, HI ? 12'h041 : 12'h000, 1'b0);
    bump(998);
    chk("bump998_score", score, 998);
    tick(12'h998, HI ? 12'h041 : 12'h000, 1'b0);
    set_move(1'b1);
    tick(12'h999, HI ? 12'h041 : 12'h000, 1'b0);
    chk("sat_reach_score", score, 999);
    set_move(1'b0);
    tick(12'h999, HI ? 12'h041 : 12'h000, 1'b0);
    set_move(1'b1);
    tick(12'h999, HI ? 12'h041 : 12'h000, 1'b0);
    chk("sat_hold_score", score, 999);
    @(negedge clk);
    vpos = 10'd480;
    hpos = 10'd0;
    @(negedge clk);
    vpos = 10'd0;
    hpos = 10'd5;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", state, 0);
    chk("midrst_score", score, 0);
    chk("midrst_score_bcd", sbcd, 0);
    chk("midrst_hiscore_bcd", hbcd, 0);
    chk("midrst_valid", valid, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_ctrl.md
# score_ctrl

Game-score controller feeding the banner digit renderer. It counts score while the move button is held, on a per-frame cadence, and sequences the game states idle, playing and over. Once per frame it converts the binary score to three BCD digits with a sequential double-dabble. The renderer reads registered digits that change only during vertical blank, so it needs no divide or modulo logic and never shows a torn value.

## Interface
Parameters:
- FRAME_LINE, 480: i_vpos value that defines the per-frame tick; must be outside the banner rows.
- HOLD_FRAMES, 8: frames between repeat increments while move is held; range 1..255.
- SCORE_MAX, 999: saturation value of the score.

Ports:
- i_clk, in, 1: pixel clock.
- i_rst_n, in, 1: reset, synchronous, active-low. Clock is i_clk.
- i_vpos, in, 10: current line.
- i_hpos, in, 10: current pixel.
- i_move, in, 1: move button, debounced but asynchronous to i_clk.
- i_game_start, in, 1: single-cycle start request.
- i_game_over, in, 1: single-cycle collision or death request.
- o_state, out, 2: game state, encoded IDLE=0, PLAYING=1, OVER=2.
- o_score, out, 10: binary score.
- o_score_bcd, out, 12: {hundreds, tens, ones}, 4 bits each.
- o_hiscore_bcd, out, 12: high score in BCD; see Configuration.
- o_bcd_valid, out, 1: one-cycle pulse when the BCD outputs update.

## Operation
- Reset values: state IDLE, o_score 0, o_score_bcd 0, o_hiscore_bcd 0, o_bcd_valid 0, hold counter 0, converter idle.
- Reset is only via i_rst_n; a reset mid-conversion aborts it and outputs return to 0.
- i_move passes through a 2-flop synchronizer before use.
- Frame tick: single-cycle pulse when i_vpos==FRAME_LINE and i_hpos==0.
- Game FSM transitions:
  - IDLE → PLAYING on i_game_start; o_score cleared to 0.
  - PLAYING → OVER on i_game_over.
  - OVER → PLAYING on i_game_start; score cleared.
  - i_game_start in PLAYING is ignored; i_game_over outside PLAYING is ignored.
- Increments happen only in PLAYING and only on a frame tick:
  - First tick with move held: increment, hold counter set to HOLD_FRAMES-1.
  - Each later tick while held: if the counter is 0, increment and reload HOLD_FRAMES-1; otherwise decrement.
  - Any tick with move released clears the counter, so the next press increments immediately.
- Saturation: score holds at SCORE_MAX. An increment at SCORE_MAX is dropped with no wrap.
- Same-cycle i_game_over and increment tick: game over wins. The increment is dropped and OVER is entered with the pre-increment score.
- Converter FSM, states CV_IDLE → CV_LOAD → CV_SHIFT → CV_DONE → CV_IDLE:
  - Starts on the cycle after a frame tick.
  - CV_LOAD latches o_score.
  - CV_SHIFT runs exactly 10 shift/add-3 iterations.
  - CV_DONE writes o_score_bcd and pulses o_bcd_valid.
- A frame tick arriving while the converter is busy is ignored. This cannot occur with legal VGA timing.

## Timing
- Frame tick at cycle F: the score register updates, new value visible at F+1.
- F+1: CV_LOAD.
- F+2..F+11: ten shift cycles.
- F+12: o_score_bcd updated and o_bcd_valid high for one cycle.
- With SCORE_HISCORE_EN, a second pass runs on the high score: load F+12, shifts F+13..F+22, o_hiscore_bcd updated at F+23 with a second o_bcd_valid pulse.
- o_state updates the cycle after the request.

## Configuration
- SCORE_HISCORE_EN defined:
  - A 10-bit high-score register, reset 0.
  - On entry to OVER, if score > high score, the high score is loaded with the score.
  - The converter performs the second pass and drives o_hiscore_bcd.
- SCORE_HISCORE_EN undefined:
  - No high-score register and no second pass.
  - o_hiscore_bcd is tied to 0.
  - Exactly one o_bcd_valid pulse per frame.

## Structure
- score_pkg holds:
  - the game-state and converter-state typedefs;
  - BCD_DIGITS=3, BCD_W=12, SCORE_W=10 constants.
- Sub-module bin2bcd_seq: sequential 10-bit to 3-digit double-dabble.
  - Ports: start, bin, busy, done, bcd.
  - Instantiated once; shared between the score and high-score passes via an input mux.

## Test plan
- Reset, then start, then move held for 1 tick: o_score=1. At F+12, o_score_bcd=0x001 and o_bcd_valid pulses once.
- Move held for 17 ticks with HOLD_FRAMES=8: increments at ticks 1, 9 and 17, so o_score=3.
- Score forced to 998 and move held across ticks: reaches 999 and stays there; o_score_bcd=0x999.
- Game over on the same cycle as an increment tick at score 41: state OVER, o_score=41. With SCORE_HISCORE_EN, o_hiscore_bcd=0x041 at F+23.
- Restart from OVER: o_score=0, and the next conversion gives o_score_bcd=0x000. The high score is retained.
- i_rst_n asserted at F+5 mid-conversion: all outputs 0 on the next cycle, and no o_bcd_valid pulse occurs.
